// File: rtl/scratchpad_port_scheduler.sv
// Serialises the kernel's two scratchpad ports (A then B) onto a single request/response
// memory channel, advancing the kernel through a registered clock enable.
module scratchpad_port_scheduler #(
    parameter int ADDR_WID = 12,
    parameter int DATA_WID = 32
) (
    input  logic                mod_clk,
    input  logic                reset,
    input  logic                run,
    input  logic [63:0]         base_addr,
    input  logic [ADDR_WID-1:0] a_addr,
    input  logic [ADDR_WID-1:0] b_addr,
    input  logic                a_ce,
    input  logic                b_ce,
    input  logic                a_we,
    input  logic                b_we,
    input  logic [DATA_WID-1:0] a_d,
    input  logic [DATA_WID-1:0] b_d,
    output logic [DATA_WID-1:0] a_q,
    output logic [DATA_WID-1:0] b_q,
    input  logic                kernel_done,
    output logic                kernel_ce,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [63:0]         mem_req_addr,
    output logic [DATA_WID-1:0] mem_req_wdata,
    input  logic                mem_rsp_valid,
    input  logic [DATA_WID-1:0] mem_rsp_data,
    output logic                done,
    output logic [31:0]         access_count,
    output logic [31:0]         stall_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_ISSUE_A, S_WAIT_A, S_ISSUE_B, S_WAIT_B, S_DONE
    } state_t;

    state_t              r_state;
    logic                r_kernel_ce;
    logic                r_req_valid;
    logic                r_req_we;
    logic [63:0]         r_req_addr;
    logic [DATA_WID-1:0] r_req_wdata;
    logic [DATA_WID-1:0] r_a_q;
    logic [DATA_WID-1:0] r_b_q;
    logic                r_done;
    logic [31:0]         r_access_count;
    logic [31:0]         r_stall_count;
    logic                r_a_we;
    logic                r_b_ce;
    logic                r_b_we;
    logic [ADDR_WID-1:0] r_b_addr;
    logic [DATA_WID-1:0] r_b_d;
    logic                r_kdone;

    // Word address to byte address, wrapping modulo 2^64.
    function automatic logic [63:0] byte_addr(input logic [63:0] base,
                                              input logic [ADDR_WID-1:0] word);
        byte_addr = base + {{(62-ADDR_WID){1'b0}}, word, 2'b00};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_kernel_ce    <= 1'b0;
            r_req_valid    <= 1'b0;
            r_req_we       <= 1'b0;
            r_req_addr     <= '0;
            r_req_wdata    <= '0;
            r_a_q          <= '0;
            r_b_q          <= '0;
            r_done         <= 1'b0;
            r_access_count <= '0;
            r_stall_count  <= '0;
            r_a_we         <= 1'b0;
            r_b_ce         <= 1'b0;
            r_b_we         <= 1'b0;
            r_b_addr       <= '0;
            r_b_d          <= '0;
            r_kdone        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state        <= S_RUN;
                        r_kernel_ce    <= 1'b1;
                        r_access_count <= '0;
                        r_stall_count  <= '0;
                    end
                end
                S_RUN: begin
                    r_a_we   <= a_we;
                    r_b_ce   <= b_ce;
                    r_b_we   <= b_we;
                    r_b_addr <= b_addr;
                    r_b_d    <= b_d;
                    r_kdone  <= kernel_done;
                    if (a_ce) begin
                        r_state     <= S_ISSUE_A;
                        r_kernel_ce <= 1'b0;
                        r_req_valid <= 1'b1;
                        r_req_we    <= a_we;
                        r_req_addr  <= byte_addr(base_addr, a_addr);
                        r_req_wdata <= a_d;
                    end else if (b_ce) begin
                        r_state     <= S_ISSUE_B;
                        r_kernel_ce <= 1'b0;
                        r_req_valid <= 1'b1;
                        r_req_we    <= b_we;
                        r_req_addr  <= byte_addr(base_addr, b_addr);
                        r_req_wdata <= b_d;
                    end else if (kernel_done) begin
                        r_state     <= S_DONE;
                        r_kernel_ce <= 1'b0;
                        r_done      <= 1'b1;
                    end else if (!run) begin
                        r_state     <= S_IDLE;
                        r_kernel_ce <= 1'b0;
                    end
                end
                // Request fields stay in their registers until the handshake completes.
                S_ISSUE_A, S_ISSUE_B: begin
                    r_stall_count <= sat_inc(r_stall_count);
                    if (mem_req_ready) begin
                        r_state     <= (r_state == S_ISSUE_A) ? S_WAIT_A : S_WAIT_B;
                        r_req_valid <= 1'b0;
                    end
                end
                S_WAIT_A, S_WAIT_B: begin
                    r_stall_count <= sat_inc(r_stall_count);
                    if (mem_rsp_valid) begin
                        r_access_count <= sat_inc(r_access_count);
                        if (r_state == S_WAIT_A) begin
                            if (!r_a_we) r_a_q <= mem_rsp_data;
                        end else if (!r_b_we) begin
                            r_b_q <= mem_rsp_data;
                        end
                        if (r_state == S_WAIT_A && r_b_ce) begin
                            r_state     <= S_ISSUE_B;
                            r_req_valid <= 1'b1;
                            r_req_we    <= r_b_we;
                            r_req_addr  <= byte_addr(base_addr, r_b_addr);
                            r_req_wdata <= r_b_d;
                        end else if (r_kdone) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (!run) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state     <= S_RUN;
                            r_kernel_ce <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (!run) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign kernel_ce     = r_kernel_ce;
    assign mem_req_valid = r_req_valid;
    assign mem_req_we    = r_req_we;
    assign mem_req_addr  = r_req_addr;
    assign mem_req_wdata = r_req_wdata;
    assign a_q           = r_a_q;
    assign b_q           = r_b_q;
    assign done          = r_done;
    assign access_count  = r_access_count;
    assign stall_count   = r_stall_count;

endmodule

// File: tb/tb_scratchpad_port_scheduler.sv
// Bench for scratchpad_port_scheduler: directed scenarios with literal expectations, then
// randomized kernel traffic against a transaction-level scratchpad and memory model.
module tb_scratchpad_port_scheduler;

    localparam int AW = 12;
    localparam int DW = 32;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [31:0] wd;
    } req_t;

    logic          mod_clk = 1'b0;
    logic          reset, run, kernel_done;
    logic [63:0]   base_addr;
    logic [AW-1:0] a_addr, b_addr;
    logic          a_ce, b_ce, a_we, b_we;
    logic [DW-1:0] a_d, b_d, a_q, b_q;
    logic          kernel_ce, mem_req_valid, mem_req_ready, mem_req_we;
    logic [63:0]   mem_req_addr;
    logic [DW-1:0] mem_req_wdata, mem_rsp_data;
    logic          mem_rsp_valid, done;
    logic [31:0]   access_count, stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    scratchpad_port_scheduler #(.ADDR_WID(AW), .DATA_WID(DW)) dut (
        .mod_clk(mod_clk), .reset(reset), .run(run), .base_addr(base_addr),
        .a_addr(a_addr), .b_addr(b_addr), .a_ce(a_ce), .b_ce(b_ce),
        .a_we(a_we), .b_we(b_we), .a_d(a_d), .b_d(b_d), .a_q(a_q), .b_q(b_q),
        .kernel_done(kernel_done), .kernel_ce(kernel_ce),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .done(done),
        .access_count(access_count), .stall_count(stall_count)
    );

    always #5 mod_clk = ~mod_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic nc();
        @(negedge mod_clk);
    endtask

    task automatic restart();
        a_ce = 0; b_ce = 0; kernel_done = 0; run = 0;
        nc();
        run = 1;
        nc();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_kernel_ce"}, kernel_ce, 0);
        chk({tag, "_req_valid"}, mem_req_valid, 0);
        chk({tag, "_req_we"}, mem_req_we, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_req_addr"}, mem_req_addr, 0);
        chk({tag, "_req_wdata"}, mem_req_wdata, 0);
        chk({tag, "_a_q"}, a_q, 0);
        chk({tag, "_b_q"}, b_q, 0);
        chk({tag, "_access"}, access_count, 0);
        chk({tag, "_stall"}, stall_count, 0);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, 4095));
    endfunction

    // Random-phase model state
    logic [31:0] sp [0:4095];
    logic [31:0] ext [logic [63:0]];
    req_t        exp_q[$];
    req_t        cur, nr;
    logic [31:0] exp_aq, exp_bq, exp_acc, exp_stall;
    int          gap, turn_stall, rdy_cnt, rsp_cnt;
    bit          in_issue, rsp_busy, have_prev, abort_run;

    initial begin
        reset = 1; run = 0; kernel_done = 0; base_addr = '0;
        a_addr = '0; b_addr = '0; a_ce = 0; b_ce = 0; a_we = 0; b_we = 0;
        a_d = '0; b_d = '0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;

        nc();
        chk_all_zero("reset");

        // Single read on port A
        reset = 0; base_addr = 64'h1000; mem_req_ready = 1; run = 1;
        nc();
        chk("t1_enable", kernel_ce, 1);
        a_ce = 1; a_we = 0; a_addr = 5;
        nc();
        chk("t1_req_valid", mem_req_valid, 1);
        chk("t1_req_addr", mem_req_addr, 64'h1014);
        chk("t1_req_we", mem_req_we, 0);
        chk("t1_ce_low", kernel_ce, 0);
        a_ce = 0;
        nc();
        chk("t1_wait_valid", mem_req_valid, 0);
        mem_rsp_valid = 1; mem_rsp_data = 32'hDEAD;
        nc();
        mem_rsp_valid = 0;
        chk("t1_enable2", kernel_ce, 1);
        chk("t1_a_q", a_q, 32'hDEAD);
        chk("t1_access", access_count, 1);
        chk("t1_stall", stall_count, 2);

        // A writes 7 to word 3, B reads word 3 in the same kernel cycle
        restart();
        chk("t2_cleared_acc", access_count, 0);
        chk("t2_cleared_stall", stall_count, 0);
        a_ce = 1; a_we = 1; a_addr = 3; a_d = 7;
        b_ce = 1; b_we = 0; b_addr = 3; b_d = 32'h55;
        nc();
        chk("t2_a_we", mem_req_we, 1);
        chk("t2_a_addr", mem_req_addr, 64'h100C);
        chk("t2_a_wdata", mem_req_wdata, 7);
        a_ce = 0; b_ce = 0;
        nc();
        mem_rsp_valid = 1; mem_rsp_data = 32'h1234;
        nc();
        mem_rsp_valid = 0;
        chk("t2_b_valid", mem_req_valid, 1);
        chk("t2_b_we", mem_req_we, 0);
        chk("t2_b_addr", mem_req_addr, 64'h100C);
        chk("t2_a_q_kept", a_q, 32'hDEAD);
        nc();
        mem_rsp_valid = 1; mem_rsp_data = 7;
        nc();
        mem_rsp_valid = 0;
        chk("t2_enable", kernel_ce, 1);
        chk("t2_b_q", b_q, 7);
        chk("t2_access", access_count, 2);
        chk("t2_stall", stall_count, 4);

        // Back-pressure: ready low for 10 cycles
        restart();
        mem_req_ready = 0;
        a_ce = 1; a_we = 1; a_addr = 12'h7FF; a_d = 32'hCAFE_F00D;
        nc();
        a_ce = 0;
        for (int i = 0; i < 11; i++) begin
            chk("t3_hold_valid", mem_req_valid, 1);
            chk("t3_hold_addr", mem_req_addr, 64'h2FFC);
            chk("t3_hold_wdata", mem_req_wdata, 32'hCAFE_F00D);
            chk("t3_hold_ce", kernel_ce, 0);
            if (i == 10) mem_req_ready = 1;
            nc();
        end
        chk("t3_stall_issue", stall_count, 11);
        chk("t3_wait_valid", mem_req_valid, 0);
        mem_rsp_valid = 1; mem_rsp_data = 32'h0;
        nc();
        mem_rsp_valid = 0;
        chk("t3_enable", kernel_ce, 1);
        chk("t3_access", access_count, 1);
        chk("t3_stall", stall_count, 12);
        chk("t3_a_q_write", a_q, 32'hDEAD);

        // kernel_done together with a B access
        b_ce = 1; b_we = 0; b_addr = 2; kernel_done = 1;
        nc();
        chk("t4_b_valid", mem_req_valid, 1);
        chk("t4_b_addr", mem_req_addr, 64'h1008);
        b_ce = 0; kernel_done = 0;
        nc();
        mem_rsp_valid = 1; mem_rsp_data = 32'hBEEF;
        nc();
        mem_rsp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_done", done, 1);
            chk("t4_no_ce", kernel_ce, 0);
            nc();
        end
        chk("t4_b_q", b_q, 32'hBEEF);
        run = 0;
        nc();
        chk("t4_done_clr", done, 0);
        chk("t4_idle_ce", kernel_ce, 0);

        // Reset in WAIT_B, then a late response
        run = 1;
        nc();
        chk("t5_enable", kernel_ce, 1);
        b_ce = 1; b_we = 1; b_addr = 1; b_d = 32'h99;
        nc();
        b_ce = 0;
        nc();
        chk("t5_wait_valid", mem_req_valid, 0);
        reset = 1;
        #1;
        chk_all_zero("t5_async");
        nc();
        reset = 0; run = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h77;
        nc();
        mem_rsp_valid = 0;
        chk_all_zero("t5_late");
        run = 1;
        nc();
        chk("t5_restart", kernel_ce, 1);

        // Address wrap past 2^64
        base_addr = 64'hFFFF_FFFF_FFFF_FFFC;
        a_ce = 1; a_we = 0; a_addr = 1;
        nc();
        a_ce = 0;
        chk("t6_wrap_addr", mem_req_addr, 64'h0);
        nc();
        mem_rsp_valid = 1; mem_rsp_data = 32'h5A5A_5A5A;
        nc();
        mem_rsp_valid = 0;
        chk("t6_a_q", a_q, 32'h5A5A_5A5A);
        for (int i = 0; i < 3; i++) begin
            chk("t6_idle_kernel_ce", kernel_ce, 1);
            nc();
        end

        // Randomized traffic
        reset = 1; run = 0; a_ce = 0; b_ce = 0; kernel_done = 0;
        nc();
        reset = 0; run = 1; base_addr = 64'hFFFF_FFFF_FFFF_FFF0;
        for (int i = 0; i < 4096; i++) sp[i] = '0;
        exp_aq = '0; exp_bq = '0; exp_acc = '0; exp_stall = '0;
        gap = 0; turn_stall = 0; in_issue = 0; rsp_busy = 0; have_prev = 0; abort_run = 0;
        for (int cyc = 0; cyc < 4000 && !abort_run; cyc++) begin
            nc();
            gap++;
            if (rsp_busy) begin
                chk("r_valid_in_wait", mem_req_valid, 0);
                mem_req_ready = 1'($urandom);
                if (rsp_cnt == 0) begin
                    mem_rsp_valid = 1;
                    if (cur.we) begin
                        ext[cur.addr] = cur.wd;
                        mem_rsp_data = $urandom;
                    end else begin
                        mem_rsp_data = ext.exists(cur.addr) ? ext[cur.addr] : '0;
                    end
                    rsp_busy = 0;
                end else begin
                    mem_rsp_valid = 0;
                    mem_rsp_data = $urandom;
                    rsp_cnt--;
                end
            end else if (mem_req_valid) begin
                if (!in_issue) begin
                    in_issue = 1;
                    rdy_cnt = $urandom_range(0, 3);
                    turn_stall += rdy_cnt + 1;
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL r_unexpected_req: got addr 0x%0h, expected no request", mem_req_addr);
                        cur = '{we: mem_req_we, addr: mem_req_addr, wd: mem_req_wdata};
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                chk("r_req_we", mem_req_we, cur.we);
                chk("r_req_addr", mem_req_addr, cur.addr);
                chk("r_req_wdata", mem_req_wdata, cur.wd);
                if (rdy_cnt == 0) begin
                    mem_req_ready = 1;
                    in_issue = 0;
                    rsp_busy = 1;
                    rsp_cnt = $urandom_range(0, 3);
                    turn_stall += rsp_cnt + 1;
                end else begin
                    mem_req_ready = 0;
                    rdy_cnt--;
                end
                mem_rsp_valid = 1'($urandom);
                mem_rsp_data = $urandom;
            end else begin
                mem_req_ready = 1'($urandom);
                mem_rsp_valid = ($urandom_range(0, 3) == 0);
                mem_rsp_data = $urandom;
            end

            if (kernel_ce) begin
                exp_stall += turn_stall;
                if (have_prev) chk("r_enable_gap", gap, 1 + turn_stall);
                chk("r_outstanding", exp_q.size() + int'(in_issue) + int'(rsp_busy), 0);
                chk("r_a_q", a_q, exp_aq);
                chk("r_b_q", b_q, exp_bq);
                chk("r_access", access_count, exp_acc);
                chk("r_stall", stall_count, exp_stall);
                chk("r_done", done, 0);
                gap = 0; turn_stall = 0; have_prev = 1;
                a_ce = 1'($urandom); b_ce = 1'($urandom);
                a_we = 1'($urandom); b_we = 1'($urandom);
                a_addr = pick_addr();
                b_addr = ($urandom_range(0, 2) == 0) ? a_addr : pick_addr();
                a_d = $urandom; b_d = $urandom; kernel_done = 0;
                if (a_ce) begin
                    nr = '{we: a_we, addr: base_addr + 64'(a_addr) * 64'd4, wd: a_d};
                    exp_q.push_back(nr);
                    exp_acc++;
                    if (a_we) sp[a_addr] = a_d;
                    else exp_aq = sp[a_addr];
                end
                if (b_ce) begin
                    nr = '{we: b_we, addr: base_addr + 64'(b_addr) * 64'd4, wd: b_d};
                    exp_q.push_back(nr);
                    exp_acc++;
                    if (b_we) sp[b_addr] = b_d;
                    else exp_bq = sp[b_addr];
                end
            end else begin
                a_ce = 1'($urandom); b_ce = 1'($urandom);
                a_we = 1'($urandom); b_we = 1'($urandom);
                a_addr = pick_addr(); b_addr = pick_addr();
                a_d = $urandom; b_d = $urandom; kernel_done = 1'($urandom);
                if (gap > 64) begin
                    n_cmp++; n_bad++;
                    $display("FAIL r_timeout: got no kernel_ce for %0d cycles, expected at most 64", gap);
                    abort_run = 1;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scratchpad_port_scheduler.md
# scratchpad_port_scheduler

Clock-enable based scheduler that serialises the two scratchpad ports (A, B) of an HLS kernel onto the single-request external memory channel. The kernel runs on mod_clk and advances only in cycles where `kernel_ce` is high. Each enabled cycle's port accesses are serviced before the next enable. It replaces the clock-toggling wrapper scheme and also reports access and stall statistics.

## Interface
- ADDR_WID, 12, scratchpad word-address width per port
- DATA_WID, 32, data width
- mod_clk  in  1  block clock; the kernel shares it and advances only when `kernel_ce`=1
- reset  in  1  asynchronous, active-high
- run  in  1  level; 1 starts and keeps the kernel running, 0 returns to IDLE
- base_addr  in  64  byte base of the scratchpad image in external memory
- a_addr, b_addr  in  ADDR_WID  kernel port word addresses
- a_ce, b_ce, a_we, b_we  in  1  kernel port enables / write flags
- a_d, b_d  in  DATA_WID  kernel write data
- a_q, b_q  out  DATA_WID  registered read data returned to kernel
- kernel_done  in  1  kernel ap_done
- kernel_ce  out  1  kernel advance enable (registered)
- mem_req_valid  out  1; mem_req_ready  in  1; mem_req_we  out  1
- mem_req_addr  out  64; mem_req_wdata  out  DATA_WID
- mem_rsp_valid  in  1; mem_rsp_data  in  DATA_WID  (one response per request, reads and writes)
- done  out  1  sticky completion flag
- access_count, stall_count  out  32  statistics

## Operation
- States: IDLE, RUN, ISSUE_A, WAIT_A, ISSUE_B, WAIT_B, DONE.
- `kernel_ce` = (state==RUN). Kernel port signals are sampled only at the edge closing a RUN cycle.
- IDLE: when run=1, clear both counters and go to RUN.
- RUN, at the closing edge: latch addr, we and d for both ports.
  - a_ce=1 -> ISSUE_A.
  - Else b_ce=1 -> ISSUE_B.
  - Else kernel_done=1 -> DONE.
  - Else run=0 -> IDLE.
  - Else stay in RUN.
- ISSUE_x: drive mem_req_valid=1, we=latched we, addr=base_addr+(latched addr<<2) computed mod 2^64 with zero-extension, wdata=latched d. On mem_req_ready -> WAIT_x.
- WAIT_x: on mem_rsp_valid, load x_q from mem_rsp_data for reads only (x_q is unchanged on writes). Next state:
  - From A: ISSUE_B if b_ce was latched.
  - Otherwise: DONE if kernel_done was latched; IDLE if run=0; else RUN.
- A is always serviced before B. A-write/B-read to the same address: B returns the new data. Both ports write the same address: B's value persists.
- mem_rsp_valid outside WAIT states is ignored. mem_req_* fields are held stable while valid=1 and ready=0.
- DONE: done=1, kernel_ce=0. When run=0 -> IDLE, which clears done.
- access_count: +1 per accepted response. stall_count: +1 per cycle in ISSUE or WAIT states. Both saturate at 2^32-1.
- run=0 during ISSUE or WAIT: the in-flight pair completes, then IDLE.

## Timing
- Reset (asynchronous) gives:
  - State IDLE.
  - kernel_ce, mem_req_valid, mem_req_we, done = 0.
  - mem_req_addr, mem_req_wdata, a_q, b_q, access_count, stall_count = 0.
- Reset mid-transaction drops mem_req_valid immediately. Late responses are ignored.
- All outputs are registered. IDLE->RUN takes 1 cycle after run rises.
- Single access, ready=1, response on the cycle after acceptance: RUN, ISSUE, WAIT, RUN. Enables are 3 cycles apart and stall_count +=2.
- Dual access, same conditions: enables are 5 cycles apart and stall_count +=4.
- No access: kernel_ce stays high every cycle.
- x_q is valid in the RUN cycle following its access and holds until the next read on that port.

## Test plan
- base=0x1000, a_ce=1, a_we=0, a_addr=5, ready=1, rsp=0xDEAD next cycle -> mem_req_addr=0x1014, a_q=0xDEAD at the next kernel_ce, access_count=1, stall_count=2.
- Same cycle: A writes 7 to addr 3 and B reads addr 3, with a memory model -> A request precedes B, b_q=7, access_count=2, stall_count=4.
- mem_req_ready held low 10 cycles -> req fields stable, kernel_ce=0 throughout, stall_count=11 at the end of ISSUE_A.
- kernel_done=1 with b_ce=1 in the same RUN cycle -> B serviced, then DONE with done=1 and no further kernel_ce. run=0 -> IDLE, done=0.
- reset asserted in WAIT_B, then rsp_valid pulses -> all outputs 0 immediately, counters stay 0. run=1 restarts from RUN.
- base=0xFFFF_FFFF_FFFF_FFFC, addr=1 -> mem_req_addr=0x0 (wrap).
